// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Walks the pixel clock through each line and frame, and publishes the current coordinate plus
// the visible-area flag and a frame marker for the colour driver. The colour that driver returns
// is registered onto the DAC pins. Sync and blanking are delayed to line up with that colour.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [9:0]  current_row,
  output logic [9:0]  current_line,
  output logic        enable,
  output logic        frame_start,
  output logic        pixel_tick,
  input  logic [11:0] color_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit decode constants so the totals can never overflow the compare.
  localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HVis    = 11'(H_VISIBLE);
  localparam logic [10:0] VVis    = 11'(V_VISIBLE);
  localparam logic [10:0] HsStart = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HsEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VsStart = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VsEnd   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [3:0]  DivLast = 4'(CLK_DIV - 1);

  // Pipeline entry layout: {hs, vs, enable}.
  localparam logic [2:0]  PipeIdle = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [3:0]  div_cnt;
  logic        tick;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_last;
  logic        v_last;
  logic        hs_raw;
  logic        vs_raw;
  logic [2:0]  sync_pipe [SYNC_DELAY];
  logic [2:0]  pipe_out;

  assign tick   = (div_cnt == DivLast);
  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_last = (h_ext == HLast);
  assign v_last = (v_ext == VLast);

  // Pixel-rate divider: free-running modulo-CLK_DIV counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= 4'd0;
    end else if (tick) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Raster counters: advance one pixel per tick, wrapping line then frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= 10'd0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Frame marker: set by the same edge that wraps the counters to (0,0), so it never fires
  // for the (0,0) left behind by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_last && v_last;
    end
  end

  // Coordinate outputs and raw decode, all straight off the counter registers.
  always_comb begin
    current_row  = h_cnt;
    current_line = v_cnt;
    pixel_tick   = tick && !rst_in;
    enable       = (h_ext < HVis) && (v_ext < VVis);
    hs_raw       = ((h_ext >= HsStart) && (h_ext < HsEnd)) ? SYNC_POL : ~SYNC_POL;
    vs_raw       = ((v_ext >= VsStart) && (v_ext < VsEnd)) ? SYNC_POL : ~SYNC_POL;
  end

  // Delay line matching the colour driver's latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < int'(SYNC_DELAY); k++) begin
        sync_pipe[k] <= PipeIdle;
      end
    end else begin
      sync_pipe[0] <= {hs_raw, vs_raw, enable};
      for (int k = 1; k < int'(SYNC_DELAY); k++) begin
        sync_pipe[k] <= sync_pipe[k-1];
      end
    end
  end

  assign pipe_out = sync_pipe[SYNC_DELAY-1];

  // Pin register: delayed sync plus colour, blanked outside the visible window.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
    end else begin
      vga_hs <= pipe_out[2];
      vga_vs <= pipe_out[1];
      {vga_r, vga_g, vga_b} <= pipe_out[0] ? color_in : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing plus two shrunken rasters with
// different divider, delay and polarity) compared every cycle against an arithmetic model
// driven by the count of clock edges since reset release.
module tb_vga_timing_gen;

  localparam int N = 3;
  localparam int CD  [N] = '{4, 1, 3};
  localparam int DL  [N] = '{1, 3, 8};
  localparam int POL [N] = '{0, 0, 1};
  localparam int HV  [N] = '{640, 20, 8};
  localparam int HF  [N] = '{16, 2, 1};
  localparam int HS  [N] = '{96, 3, 2};
  localparam int HB  [N] = '{48, 3, 1};
  localparam int VV  [N] = '{480, 10, 4};
  localparam int VF  [N] = '{10, 1, 1};
  localparam int VS  [N] = '{2, 2, 1};
  localparam int VB  [N] = '{33, 2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] color = 12'hF00;
  logic [9:0]  row  [N];
  logic [9:0]  line [N];
  logic        en   [N];
  logic        fs   [N];
  logic        pt   [N];
  logic [3:0]  r    [N];
  logic [3:0]  g    [N];
  logic [3:0]  b    [N];
  logic        hs   [N];
  logic        vs   [N];

  int          t;
  logic [11:0] last_col;
  int          checks = 0;
  int          errors = 0;
  bit          const_col = 1'b1;

  int  hrun [N];
  int  vrun [N];
  bit  hval [N];
  bit  vval [N];
  int  last_fs [N];

  vga_timing_gen #(
    .CLK_DIV(CD[0]), .H_VISIBLE(HV[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
    .V_VISIBLE(VV[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]),
    .SYNC_POL(POL[0] != 0), .SYNC_DELAY(DL[0])
  ) dut0 (
    .clk_in(clk), .rst_in(rst), .current_row(row[0]), .current_line(line[0]),
    .enable(en[0]), .frame_start(fs[0]), .pixel_tick(pt[0]), .color_in(color),
    .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_hs(hs[0]), .vga_vs(vs[0])
  );

  vga_timing_gen #(
    .CLK_DIV(CD[1]), .H_VISIBLE(HV[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
    .V_VISIBLE(VV[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
    .SYNC_POL(POL[1] != 0), .SYNC_DELAY(DL[1])
  ) dut1 (
    .clk_in(clk), .rst_in(rst), .current_row(row[1]), .current_line(line[1]),
    .enable(en[1]), .frame_start(fs[1]), .pixel_tick(pt[1]), .color_in(color),
    .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_hs(hs[1]), .vga_vs(vs[1])
  );

  vga_timing_gen #(
    .CLK_DIV(CD[2]), .H_VISIBLE(HV[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
    .V_VISIBLE(VV[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]),
    .SYNC_POL(POL[2] != 0), .SYNC_DELAY(DL[2])
  ) dut2 (
    .clk_in(clk), .rst_in(rst), .current_row(row[2]), .current_line(line[2]),
    .enable(en[2]), .frame_start(fs[2]), .pixel_tick(pt[2]), .color_in(color),
    .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_hs(hs[2]), .vga_vs(vs[2])
  );

  always #5 clk = ~clk;

  // Edge count since reset release, and the colour each edge captured.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= 0;
    end else begin
      t        <= t + 1;
      last_col <= color;
    end
  end

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0d got %h want %h", name, inst, t, act, exp);
    end
  endtask

  function automatic int htot(int i);
    return HV[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(int i);
    return VV[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // {row, line, enable, frame_start, pixel_tick, rgb, hs, vs} while reset is held.
  function automatic logic [36:0] reset_bundle(int i);
    logic p;
    p = (POL[i] != 0);
    return {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 12'h000, ~p, ~p};
  endfunction

  // Expected outputs tt edges after reset release: pixel index = tt / CLK_DIV, coordinates
  // follow by division; pins show the raster as it stood SYNC_DELAY+1 edges earlier.
  function automatic logic [36:0] model(int i, int tt, logic [11:0] col);
    int pix, h, v, td, hd, vd;
    logic p, e, f, k, hsv, vsv;
    logic [11:0] rgb;
    p   = (POL[i] != 0);
    pix = tt / CD[i];
    h   = pix % htot(i);
    v   = (pix / htot(i)) % vtot(i);
    e   = (h < HV[i]) && (v < VV[i]);
    k   = (tt % CD[i]) == CD[i] - 1;
    f   = (pix > 0) && (tt % CD[i] == 0) && (pix % (htot(i) * vtot(i)) == 0);
    td  = tt - DL[i] - 1;
    if (td < 0) begin
      hsv = ~p;
      vsv = ~p;
      rgb = 12'h000;
    end else begin
      hd  = (td / CD[i]) % htot(i);
      vd  = ((td / CD[i]) / htot(i)) % vtot(i);
      hsv = (hd >= HV[i] + HF[i] && hd < HV[i] + HF[i] + HS[i]) ? p : ~p;
      vsv = (vd >= VV[i] + VF[i] && vd < VV[i] + VF[i] + VS[i]) ? p : ~p;
      rgb = (hd < HV[i] && vd < VV[i]) ? col : 12'h000;
    end
    return {10'(h), 10'(v), e, f, k, rgb, hsv, vsv};
  endfunction

  // Per-cycle comparison plus pulse-width / period measurements and fixed-point literals.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [36:0] exp, act;
      logic p;
      p   = (POL[i] != 0);
      act = {row[i], line[i], en[i], fs[i], pt[i], r[i], g[i], b[i], hs[i], vs[i]};
      exp = rst ? reset_bundle(i) : model(i, t, last_col);
      check("cycle", i, act, exp);
      if (rst) begin
        hrun[i] = 0; vrun[i] = 0; hval[i] = 1'b0; vval[i] = 1'b0; last_fs[i] = -1;
      end else begin
        if (hs[i] != p) begin
          if (hval[i] && hrun[i] > 0) check("hs_width", i, hrun[i], HS[i] * CD[i]);
          hrun[i] = 0; hval[i] = 1'b1;
        end else begin
          hrun[i]++;
        end
        if (vs[i] != p) begin
          if (vval[i] && vrun[i] > 0) check("vs_width", i, vrun[i], VS[i] * htot(i) * CD[i]);
          vrun[i] = 0; vval[i] = 1'b1;
        end else begin
          vrun[i]++;
        end
        if (fs[i]) begin
          if (last_fs[i] >= 0) check("fs_period", i, t - last_fs[i], htot(i) * vtot(i) * CD[i]);
          last_fs[i] = t;
        end
      end
    end
    if (!rst) begin
      if (t == 3)    check("tick_first", 0, pt[0], 1);
      if (t == 4)    check("row_after_4", 0, row[0], 1);
      if (t == 3200) check("line_wrap", 0, {row[0], line[0]}, {10'd0, 10'd1});
      if (t == 2625) check("hs_before", 0, hs[0], 1);
      if (t == 2626) check("hs_fall", 0, hs[0], 0);
      if (const_col && t == 100)  check("red_visible", 0, r[0], 4'hF);
      if (const_col && t == 2561) check("red_last", 0, r[0], 4'hF);
      if (const_col && t == 2562) check("red_blank", 0, {r[0], g[0], b[0]}, 12'h000);
      if (t == 25)  check("hs_before", 1, hs[1], 1);
      if (t == 26)  check("hs_fall", 1, hs[1], 0);
      if (t == 28)  check("line_wrap", 1, {row[1], line[1]}, {10'd0, 10'd1});
      if (t == 420) check("frame_pulse", 1, fs[1], 1);
      if (t == 35)  check("hs_before", 2, hs[2], 0);
      if (t == 36)  check("hs_rise", 2, hs[2], 1);
    end
  end

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2 color = 12'($urandom);
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // First line and a bit with solid red, then random colour.
    repeat (3300) @(posedge clk);
    #2 const_col = 1'b0;
    run_random(3300);

    // Land in the middle of an hsync pulse on the default raster, then reset asynchronously.
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(posedge clk);
      #2 color = 12'($urandom);
      if ((t / 4) % 800 >= 670 && (t / 4) % 800 <= 740) found = 1'b1;
    end
    check("hsync_wait", 0, found, 1);
    check("pre_reset_hs", 0, hs[0], 0);
    rst = 1'b1;
    #1;
    check("async_hs", 0, hs[0], 1);
    check("async_vs", 0, vs[0], 1);
    check("async_rgb", 0, {r[0], g[0], b[0]}, 12'h000);
    check("async_pos", 0, {row[0], line[0]}, 20'd0);
    check("async_pulses", 0, {fs[0], pt[0]}, 2'b00);
    check("async_hs", 2, hs[2], 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;

    // Random run lengths with random async reset pulses in between.
    for (int k = 0; k < 3; k++) begin
      run_random(int'($urandom_range(500, 3000)));
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (int'($urandom_range(1, 5))) @(posedge clk);
      #2 rst = 1'b0;
    end
    run_random(3500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
